redundant_carry_resolver: RTL and testbench

REDUNDANT_CARRY_RESOLVER -- requirements
Module: redundant_carry_resolver

---
 rtl/redundant_carry_resolver.sv | 142 ++++++++++++++
 tb/tb_redundant_carry_resolver.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redundant_carry_resolver.sv
// Streams redundant 48-bit limbs (LSB first) and resolves them into canonical LIMB_BITS-wide limbs,
// rippling the carry serially and optionally emitting the final carry as one extra limb.
module redundant_carry_resolver #(
  parameter int unsigned NUM_LIMBS  = 8,
  parameter int unsigned LIMB_BITS  = 32,
  parameter int unsigned EMIT_CARRY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [47:0]          in_limb,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LIMB_BITS-1:0] out_limb,
  output logic                 out_last,
  output logic                 err_len
);

  localparam int unsigned IN_BITS    = 48;
  localparam int unsigned SUM_BITS   = IN_BITS + 1;
  localparam int unsigned CARRY_BITS = SUM_BITS - LIMB_BITS;
  localparam int unsigned K_BITS     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(NUM_LIMBS - 1);
  localparam bit EMIT = (EMIT_CARRY != 0);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]            r_state;
  logic [CARRY_BITS-1:0] r_c;
  logic [K_BITS-1:0]     r_k;
  logic                  r_out_valid;
  logic [LIMB_BITS-1:0]  r_out_limb;
  logic                  r_out_last;
  logic                  r_err_len;

  logic [0:0]            w_state_nxt;
  logic [CARRY_BITS-1:0] w_c_nxt;
  logic [K_BITS-1:0]     w_k_nxt;
  logic                  w_out_valid_nxt;
  logic [LIMB_BITS-1:0]  w_out_limb_nxt;
  logic                  w_out_last_nxt;
  logic                  w_err_len_nxt;

  logic [SUM_BITS-1:0]   w_sum;
  logic [CARRY_BITS-1:0] w_c_next;
  logic [LIMB_BITS-1:0]  w_carry_limb;
  logic                  w_out_free;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_at_last_k;
  logic                  w_is_last;

  // Carry-save resolution of one beat; the sum always fits 49 bits.
  assign w_sum        = SUM_BITS'(in_limb) + SUM_BITS'(r_c);
  assign w_c_next     = w_sum[SUM_BITS-1:LIMB_BITS];
  assign w_carry_limb = LIMB_BITS'(r_c);

  // Output register is free when empty or being drained this cycle.
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_in_ready  = !reset && (r_state == S_RUN) && w_out_free;
  assign w_accept    = in_valid && w_in_ready;
  assign w_at_last_k = (r_k == K_LAST);
  assign w_is_last   = in_last || w_at_last_k;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_c_nxt         = r_c;
    w_k_nxt         = r_k;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_out_limb_nxt  = r_out_limb;
    w_out_last_nxt  = r_out_last;
    w_err_len_nxt   = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          w_out_valid_nxt = 1'b1;
          w_out_limb_nxt  = w_sum[LIMB_BITS-1:0];
          w_err_len_nxt   = in_last ^ w_at_last_k;
          if (!w_is_last) begin
            w_out_last_nxt = 1'b0;
            w_c_nxt        = w_c_next;
            w_k_nxt        = r_k + K_BITS'(1);
          end else if (EMIT) begin
            w_out_last_nxt = 1'b0;
            w_c_nxt        = w_c_next;
            w_state_nxt    = S_FLUSH;
          end else begin
            w_out_last_nxt = 1'b1;
            w_c_nxt        = '0;
            w_k_nxt        = '0;
          end
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_limb_nxt  = w_carry_limb;
          w_out_last_nxt  = 1'b1;
          w_c_nxt         = '0;
          w_k_nxt         = '0;
          w_state_nxt     = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_c         <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_limb  <= '0;
      r_out_last  <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_c         <= w_c_nxt;
      r_k         <= w_k_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_limb  <= w_out_limb_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err_len   <= w_err_len_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_limb  = r_out_limb;
  assign out_last  = r_out_last;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_redundant_carry_resolver.sv
// Random and directed stimulus for two resolver instances (with and without carry limb),
// checked against a big-integer model of each operand's value.
module tb_redundant_carry_resolver;

  localparam int unsigned NL = 4;
  localparam int unsigned LB = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv    [2];
  logic        ir    [2];
  logic [47:0] il    [2];
  logic        ilast [2];
  logic        ov    [2];
  logic        ordy  [2];
  logic [31:0] ol    [2];
  logic        olast [2];
  logic        err   [2];

  logic [32:0] q0[$];
  logic [32:0] q1[$];

  int          checks = 0;
  int          errors = 0;
  int          rmode  = 0;
  int          cyc    = 0;
  int          beat_cycles = 0;
  logic        exp_err [2];
  logic        stall   [2];
  logic [31:0] st_limb [2];
  logic        st_last [2];
  logic        drv_mm  [2];

  always #5 clk = ~clk;

  redundant_carry_resolver #(.NUM_LIMBS(NL), .LIMB_BITS(LB), .EMIT_CARRY(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_limb(il[0]), .in_last(ilast[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_limb(ol[0]), .out_last(olast[0]),
    .err_len(err[0])
  );

  redundant_carry_resolver #(.NUM_LIMBS(NL), .LIMB_BITS(LB), .EMIT_CARRY(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_limb(il[1]), .in_last(ilast[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_limb(ol[1]), .out_last(olast[1]),
    .err_len(err[1])
  );

  // Output limb idx of the operand value sum(op[i] * 2^(32i)); idx == len gives the carry limb.
  function automatic logic [31:0] model_limb(input logic [47:0] op[NL], input int len, input int idx);
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = v + (192'(op[i]) << (32 * i));
    return 32'(v >> (32 * idx));
  endfunction

  function automatic logic [47:0] rnd_limb();
    case ($urandom_range(0, 3))
      0:       return 48'hFFFF_FFFF_FFFF;
      1:       return {16'($urandom), 32'hFFFF_FFFF};
      default: return {16'($urandom), 32'($urandom)};
    endcase
  endfunction

  // out_ready: 0 = always high, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        case (rmode)
          1:       ordy[u] = pat[cyc % 4];
          2:       ordy[u] = 1'($urandom_range(0, 1));
          default: ordy[u] = 1'b1;
        endcase
      end
      cyc++;
    end
  end

  // Per-cycle compare of both instances against their expectation queues.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [32:0] e;
      logic        empty;
      checks++;
      if (err[u] !== exp_err[u]) begin
        errors++;
        $display("FAIL err_len u%0d: got %b want %b at %0t", u, err[u], exp_err[u], $time);
      end
      exp_err[u] = iv[u] && ir[u] && drv_mm[u];
      if (reset) begin
        checks++;
        if (ir[u] !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_in_reset u%0d: got %b want 0", u, ir[u]);
        end
        stall[u] = 1'b0;
      end else begin
        if (stall[u]) begin
          checks++;
          if (ov[u] !== 1'b1 || ol[u] !== st_limb[u] || olast[u] !== st_last[u]) begin
            errors++;
            $display("FAIL stall_hold u%0d: got v=%b %h/%b want v=1 %h/%b", u, ov[u], ol[u], olast[u],
                     st_limb[u], st_last[u]);
          end
        end
        stall[u]   = ov[u] && !ordy[u];
        st_limb[u] = ol[u];
        st_last[u] = olast[u];
        if (ov[u] && ordy[u]) begin
          checks++;
          empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            errors++;
            $display("FAIL extra_out u%0d: got %h/%b want nothing", u, ol[u], olast[u]);
          end else begin
            if (u == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if ({olast[u], ol[u]} !== e) begin
              errors++;
              $display("FAIL out_beat u%0d: got %h last=%b want %h last=%b at %0t", u, ol[u], olast[u],
                       e[31:0], e[32], $time);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int u, input logic [47:0] op[NL], input int len);
    for (int i = 0; i < len; i++) begin
      if (u == 0) q0.push_back({1'b0, model_limb(op, len, i)});
      else        q1.push_back({i == len - 1, model_limb(op, len, i)});
    end
    if (u == 0) q0.push_back({1'b1, model_limb(op, len, len)});
  endtask

  task automatic send_beat(input int u, input logic [47:0] d, input logic lst, input logic mm);
    bit acc;
    int n;
    iv[u] = 1'b1; il[u] = d; ilast[u] = lst; drv_mm[u] = mm;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = ir[u];
      @(posedge clk);
      #1;
      n++;
    end
    beat_cycles += n;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout u%0d: got no in_ready within %0d cycles", u, n);
    end
    iv[u] = 1'b0;
  endtask

  task automatic send_op(input int u, input logic [47:0] op[NL], input int len, input bit mark_last,
                         input int abort_after, input bit gaps);
    push_exp(u, op, len);
    for (int i = 0; i < len; i++) begin
      logic lst;
      if (abort_after > 0 && i == abort_after) break;
      lst = mark_last && (i == len - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        iv[u] = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(u, op[i], lst, lst != (i == NL - 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ov[u] !== 1'b0 || ol[u] !== 32'h0 || olast[u] !== 1'b0 || err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state u%0d: got v=%b limb=%h last=%b err=%b want all 0", u, ov[u], ol[u],
                 olast[u], err[u]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic pin(input string name, input logic [47:0] op[NL], input int len, input int cnt,
                     input logic [31:0] want[5]);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] got;
      got = model_limb(op, len, i);
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL model_%s[%0d]: got %h want %h", name, i, got, want[i]);
      end
    end
  endtask

  task automatic rand_ops(input int u, input int cnt, input bit vary);
    logic [47:0] op[NL];
    int len;
    bit mark;
    for (int k = 0; k < cnt; k++) begin
      for (int i = 0; i < NL; i++) op[i] = rnd_limb();
      len = NL;
      mark = 1'b1;
      if (vary) begin
        case ($urandom_range(0, 5))
          0:       len = $urandom_range(1, NL - 1);
          1:       mark = 1'b0;
          default: len = NL;
        endcase
      end
      send_op(u, op, len, mark, 0, 1'b1);
    end
  endtask

  initial begin
    logic [47:0] op[NL];
    logic [31:0] want[5];
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; il[u] = '0; ilast[u] = 1'b0; drv_mm[u] = 1'b0;
      exp_err[u] = 1'b0; stall[u] = 1'b0; st_limb[u] = '0; st_last[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Pin the model with hand-derived values.
    op = '{48'hFFFF_FFFF, 48'h1, 48'h0, 48'h0};
    want = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0};
    pin("small", op, 4, 5, want);
    op = '{48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF};
    want = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1, 32'h2};
    pin("ripple", op, 4, 5, want);
    op = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    want = '{32'hFFFF_FFFF, 32'h0000_FFFE, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0001_0000};
    pin("ones", op, 4, 5, want);

    // Directed operands on the carry-emitting instance.
    op = '{48'hFFFF_FFFF, 48'h1, 48'h0, 48'h0};
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    op = '{48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF, 48'h1_FFFF_FFFF};
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    op = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0};
    send_op(0, op, 3, 1'b1, 0, 1'b0);
    op = '{48'h1, 48'h0, 48'h0, 48'h0};
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    op = '{48'hFFFF_FFFF_FFFF, 48'h7, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    send_op(0, op, 4, 1'b0, 0, 1'b0);

    // Abort after two limbs with carry 5 pending, then a clean operand.
    op = '{48'h1_0000_0000, 48'h5_0000_0000, 48'h0, 48'h0};
    send_op(0, op, 4, 1'b1, 2, 1'b0);
    do_reset();
    op = '{48'h1, 48'h0, 48'h0, 48'h0};
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    wait_drain();

    // Back-to-back throughput: two operands take 4 + 1 + 4 accept cycles.
    op = '{48'h3_0000_0001, 48'h2, 48'hFFFF_0000_0000, 48'h9};
    beat_cycles = 0;
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    send_op(0, op, 4, 1'b1, 0, 1'b0);
    checks++;
    if (beat_cycles != 9) begin
      errors++;
      $display("FAIL throughput_emit: got %0d cycles want 9", beat_cycles);
    end
    wait_drain();

    rmode = 1;
    rand_ops(0, 1000, 1'b0);
    wait_drain();
    rmode = 2;
    rand_ops(0, 150, 1'b1);
    wait_drain();

    // Carry-discarding instance.
    rmode = 0;
    op = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
    beat_cycles = 0;
    send_op(1, op, 4, 1'b1, 0, 1'b0);
    op = '{48'h1, 48'h0, 48'h0, 48'h0};
    send_op(1, op, 4, 1'b1, 0, 1'b0);
    checks++;
    if (beat_cycles != 8) begin
      errors++;
      $display("FAIL throughput_noemit: got %0d cycles want 8", beat_cycles);
    end
    wait_drain();
    rmode = 2;
    rand_ops(1, 200, 1'b1);
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
